// File: rtl/bp_pkg.sv
// Shared types and counter helpers for the branch-predictor pattern history table.
package bp_pkg;

  typedef enum logic {BP_INIT, BP_RUN} bp_state_e;

  // Counter helpers work on a 32-bit carrier so any CTR_W up to 32 can share them.
  function automatic logic [31:0] ctr_max(input int ctr_w);
    return (ctr_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ctr_w) - 32'd1);
  endfunction

  // Even banks start strong not-taken, odd banks strong taken.
  function automatic logic [31:0] ctr_init(input int bank, input int ctr_w);
    return bank[0] ? ctr_max(ctr_w) : 32'd0;
  endfunction

  function automatic logic [31:0] ctr_sat_next(input logic [31:0] ctr, input logic taken,
                                               input int ctr_w);
    if (taken) return (ctr == ctr_max(ctr_w)) ? ctr : ctr + 32'd1;
    return (ctr == 32'd0) ? ctr : ctr - 32'd1;
  endfunction

endpackage

// File: rtl/bp_init_sweep.sv
// Post-reset sweep controller: walks every table index once, then reports ready.
module bp_init_sweep #(
  parameter int INDEX_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  output logic               ready,
  output logic               sweep_we,
  output logic [INDEX_W-1:0] sweep_idx
);
  import bp_pkg::*;

  localparam logic [INDEX_W-1:0] LAST_IDX = {INDEX_W{1'b1}};

  bp_state_e state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BP_INIT;
      sweep_idx <= '0;
      ready     <= 1'b0;
    end else if (state == BP_INIT) begin
      sweep_idx <= sweep_idx + 1'b1;
      if (sweep_idx == LAST_IDX) begin
        state <= BP_RUN;
        ready <= 1'b1;
      end
    end
  end

  assign sweep_we = (state == BP_INIT) && !rst;

endmodule

// File: rtl/bp_pattern_table.sv
// Multi-bank PHT of saturating counters: combinational IF lookup, EX read-modify-write,
// optional gshare hashing and same-cycle update bypass.
module bp_pattern_table #(
  parameter  int INDEX_W   = 4,
  parameter  int CTR_W     = 2,
  parameter  int NUM_BANKS = 2,
  parameter  int HIST_W    = 4,
  parameter  int USE_GHR   = 0,
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int DEPTH     = 2 ** INDEX_W
) (
  input  logic               clk,
  input  logic               rst,
  output logic               ready,
  input  logic [INDEX_W-1:0] lookup_idx_if,
  input  logic [BANK_W-1:0]  bank_if,
  output logic [INDEX_W-1:0] pred_idx_if,
  output logic [CTR_W-1:0]   pred_ctr_if,
  output logic               pred_taken_if,
  input  logic               update_ex,
  input  logic [BANK_W-1:0]  bank_ex,
  input  logic [INDEX_W-1:0] idx_ex,
  input  logic               taken_ex
);
  import bp_pkg::*;

  function automatic logic [CTR_W-1:0] sat_next(input logic [CTR_W-1:0] c, input logic t);
    return CTR_W'(ctr_sat_next(32'(c), t, CTR_W));
  endfunction

  function automatic logic [HIST_W-1:0] ghr_shift(input logic [HIST_W-1:0] g, input logic t);
    logic [HIST_W:0] cat;
    cat = {g, t};
    return cat[HIST_W-1:0];
  endfunction

  logic [CTR_W-1:0]   table_q [NUM_BANKS][DEPTH];
  logic               sweep_we;
  logic [INDEX_W-1:0] sweep_idx;
  logic [HIST_W-1:0]  ghr;
  logic [INDEX_W-1:0] hash_idx;
  logic               upd_ok, upd_wr, bypass;
  logic [CTR_W-1:0]   upd_cur, upd_next, rd_cur;

  bp_init_sweep #(.INDEX_W(INDEX_W)) u_sweep (
    .clk       (clk),
    .rst       (rst),
    .ready     (ready),
    .sweep_we  (sweep_we),
    .sweep_idx (sweep_idx)
  );

  // GHR stays at zero when hashing is disabled, so the XOR is a no-op.
  assign hash_idx    = lookup_idx_if ^ INDEX_W'(ghr);
  assign pred_idx_if = hash_idx;

  assign upd_ok = ready && update_ex && !rst;
  assign upd_wr = upd_ok && (int'(bank_ex) < NUM_BANKS);

  always_comb begin
    upd_cur = '0;
    if (int'(bank_ex) < NUM_BANKS) upd_cur = table_q[bank_ex][idx_ex];
  end

  assign upd_next = sat_next(upd_cur, taken_ex);

  // Same-entry update in this cycle forwards the post-update value to the lookup.
  always_comb begin
    rd_cur = '0;
    if (int'(bank_if) < NUM_BANKS) rd_cur = table_q[bank_if][hash_idx];
    bypass      = upd_wr && (bank_ex == bank_if) && (idx_ex == hash_idx);
    pred_ctr_if = '0;
    if (ready) pred_ctr_if = bypass ? upd_next : rd_cur;
  end

  assign pred_taken_if = pred_ctr_if[CTR_W-1];

  always_ff @(posedge clk) begin
    if (rst) ghr <= '0;
    else if ((USE_GHR != 0) && upd_ok) ghr <= ghr_shift(ghr, taken_ex);
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (sweep_we) table_q[b][sweep_idx] <= CTR_W'(ctr_init(b, CTR_W));
      else if (upd_wr && (int'(bank_ex) == b)) table_q[b][idx_ex] <= upd_next;
    end
  end

endmodule

// File: tb/tb_bp_pattern_table.sv
// Bench for bp_pattern_table: a plain 2-bank table and a 3-bank gshare table driven in lockstep
// and compared against an array-based reference model.
module tb_bp_pattern_table;

  logic       clk;
  logic       rst;
  logic [3:0] lk;
  logic [1:0] bank_if;
  logic       update_ex;
  logic [1:0] bank_ex;
  logic [3:0] idx_ex;
  logic       taken_ex;

  logic       a_ready, a_ptaken, b_ready, b_ptaken;
  logic [3:0] a_pidx, b_pidx;
  logic [1:0] a_pctr, b_pctr;

  int ma [2][16];
  int mb [3][16];
  int ghr_m, cnt_m;
  bit rdy_m;
  int n_chk, n_err;

  bp_pattern_table #(.INDEX_W(4), .CTR_W(2), .NUM_BANKS(2), .HIST_W(4), .USE_GHR(0)) u_dut_a (
    .clk(clk), .rst(rst), .ready(a_ready),
    .lookup_idx_if(lk), .bank_if(bank_if[0]),
    .pred_idx_if(a_pidx), .pred_ctr_if(a_pctr), .pred_taken_if(a_ptaken),
    .update_ex(update_ex), .bank_ex(bank_ex[0]), .idx_ex(idx_ex), .taken_ex(taken_ex)
  );

  bp_pattern_table #(.INDEX_W(4), .CTR_W(2), .NUM_BANKS(3), .HIST_W(4), .USE_GHR(1)) u_dut_b (
    .clk(clk), .rst(rst), .ready(b_ready),
    .lookup_idx_if(lk), .bank_if(bank_if),
    .pred_idx_if(b_pidx), .pred_ctr_if(b_pctr), .pred_taken_if(b_ptaken),
    .update_ex(update_ex), .bank_ex(bank_ex), .idx_ex(idx_ex), .taken_ex(taken_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_chk++;
    if (obs !== req) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, req, $time);
    end
  endtask

  function automatic int sat(input int v, input bit t);
    int n;
    n = t ? v + 1 : v - 1;
    if (n < 0) n = 0;
    if (n > 3) n = 3;
    return n;
  endfunction

  task automatic reset_model();
    for (int b = 0; b < 2; b++) for (int i = 0; i < 16; i++) ma[b][i] = (b % 2) ? 3 : 0;
    for (int b = 0; b < 3; b++) for (int i = 0; i < 16; i++) mb[b][i] = (b % 2) ? 3 : 0;
  endtask

  task automatic check_outputs();
    int ea, eb, ba, bidx;
    ba   = int'(bank_if[0]);
    bidx = (int'(lk) ^ ghr_m) & 15;
    chk("ready_a", 32'(a_ready), 32'(rdy_m));
    chk("ready_b", 32'(b_ready), 32'(rdy_m));
    chk("idx_a", 32'(a_pidx), 32'(lk));
    chk("idx_b", 32'(b_pidx), 32'(bidx));
    ea = 0;
    if (rdy_m) begin
      ea = ma[ba][lk];
      if (update_ex && int'(bank_ex[0]) == ba && idx_ex == lk) ea = sat(ea, taken_ex);
    end
    chk("ctr_a", 32'(a_pctr), 32'(ea));
    chk("taken_a", 32'(a_ptaken), 32'(ea / 2));
    if (bank_if < 3) begin
      eb = 0;
      if (rdy_m) begin
        eb = mb[bank_if][bidx];
        if (update_ex && bank_ex == bank_if && int'(idx_ex) == bidx) eb = sat(eb, taken_ex);
      end
      chk("ctr_b", 32'(b_pctr), 32'(eb));
      chk("taken_b", 32'(b_ptaken), 32'(eb / 2));
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      rdy_m = 0; cnt_m = 0; ghr_m = 0;
      reset_model();
    end else if (!rdy_m) begin
      cnt_m++;
      if (cnt_m == 16) rdy_m = 1;
    end else if (update_ex) begin
      ma[bank_ex[0]][idx_ex] = sat(ma[bank_ex[0]][idx_ex], taken_ex);
      if (bank_ex < 3) mb[bank_ex][idx_ex] = sat(mb[bank_ex][idx_ex], taken_ex);
      ghr_m = ((ghr_m << 1) | int'(taken_ex)) & 15;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; update_ex = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic sweep_check();
    update_ex = 1'b0;
    for (int i = 0; i < 16; i++)
      for (int b = 0; b < 4; b++) begin
        lk = 4'(i); bank_if = 2'(b);
        tick();
      end
  endtask

  task automatic upd(input logic [1:0] b, input logic [3:0] i, input logic t);
    update_ex = 1'b1; bank_ex = b; idx_ex = i; taken_ex = t;
    tick();
    update_ex = 1'b0;
  endtask

  int t2_req [8] = '{1, 2, 3, 3, 2, 1, 0, 0};

  initial begin
    n_chk = 0; n_err = 0;
    rst = 1'b1; lk = '0; bank_if = '0; update_ex = 1'b0; bank_ex = '0; idx_ex = '0; taken_ex = 1'b0;
    reset_model();
    @(posedge clk);
    model_edge();
    #1;
    rst = 1'b0;

    // Reset sweep timing and default contents
    for (int i = 0; i < 16; i++) begin
      chk("t1_not_ready", 32'(a_ready), 32'd0);
      tick();
    end
    chk("t1_ready", 32'(a_ready), 32'd1);
    sweep_check();

    // Saturation up and down on bank0 idx5
    bank_if = 2'd1; lk = 4'd0;
    for (int k = 0; k < 8; k++) begin
      bank_if = 2'd1; lk = 4'd0;
      upd(2'd0, 4'd5, k < 4);
      lk = 4'd5; bank_if = 2'd0;
      #1;
      chk("t2_ctr", 32'(a_pctr), 32'(t2_req[k]));
      chk("t2_taken", 32'(a_ptaken), 32'(t2_req[k] >= 2));
      tick();
    end

    // Same-cycle bypass on bank0 idx3
    bank_if = 2'd1;
    upd(2'd0, 4'd3, 1'b1);
    lk = 4'd3; bank_if = 2'd0;
    update_ex = 1'b1; bank_ex = 2'd0; idx_ex = 4'd3; taken_ex = 1'b1;
    #1;
    chk("t3_bypass_ctr", 32'(a_pctr), 32'd2);
    chk("t3_bypass_taken", 32'(a_ptaken), 32'd1);
    tick();
    update_ex = 1'b0;

    // Reset mid-sweep, then a full sweep
    do_reset();
    for (int i = 0; i < 7; i++) tick();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      chk("t5_not_ready", 32'(b_ready), 32'd0);
      tick();
    end
    chk("t5_ready", 32'(b_ready), 32'd1);

    // GHR hashing: T,T,N then lookup 9
    lk = 4'd0; bank_if = 2'd1;
    upd(2'd0, 4'd0, 1'b1);
    upd(2'd0, 4'd0, 1'b1);
    upd(2'd0, 4'd0, 1'b0);
    lk = 4'h9;
    #1;
    chk("t4_hash_b", 32'(b_pidx), 32'hF);
    chk("t4_nohash_a", 32'(a_pidx), 32'h9);
    tick();

    // Reset in RUN after edits restores defaults and clears GHR
    do_reset();
    for (int i = 0; i < 16; i++) tick();
    lk = 4'h9;
    #1;
    chk("t5_ghr_clear", 32'(b_pidx), 32'h9);
    sweep_check();

    // Updates during INIT are ignored; bad bank shifts GHR only
    do_reset();
    for (int i = 0; i < 16; i++) begin
      update_ex = 1'b1; bank_ex = 2'd0; idx_ex = 4'd5; taken_ex = 1'b1;
      tick();
    end
    update_ex = 1'b0; lk = 4'd9;
    #1;
    chk("t6_ghr_frozen", 32'(b_pidx), 32'h9);
    lk = 4'd5; bank_if = 2'd0;
    #1;
    chk("t6_init_ignored", 32'(b_pctr), 32'd0);
    upd(2'd3, 4'd5, 1'b1);
    lk = 4'd4;
    for (int b = 0; b < 3; b++) begin
      bank_if = 2'(b);
      #1;
      chk("t6_bad_bank_b", 32'(b_pctr), (b == 1) ? 32'd3 : 32'd0);
    end
    chk("t6_bad_bank_ghr", 32'(b_pidx), 32'd5);
    upd(2'd2, 4'd5, 1'b1);
    lk = 4'd6; bank_if = 2'd2;
    #1;
    chk("t6_bank2_b", 32'(b_pctr), 32'd1);
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(63) == 0);
      lk        = 4'($urandom);
      bank_if   = 2'($urandom);
      update_ex = !rst && ($urandom_range(3) != 0);
      taken_ex  = 1'($urandom);
      case ($urandom_range(3))
        0: begin bank_ex = bank_if; idx_ex = lk; end
        1: begin bank_ex = bank_if; idx_ex = lk ^ 4'(ghr_m); end
        default: begin bank_ex = 2'($urandom); idx_ex = 4'($urandom_range(3)); end
      endcase
      tick();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
